// File: rtl/key_debounce_pulse.sv
// Pushbutton debouncer: two-flop synchronizer, four-state debounce FSM,
// one-cycle press/release pulses and a debounced "key is down" level.
module key_debounce_pulse #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clock,
   input  logic resetn,
   input  logic key_n,
   output logic press_pulse,
   output logic release_pulse,
   output logic key_down
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   logic          key_meta;
   logic          key_sync;
   logic          pressed_s;
   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic          press_nx, release_nx, key_down_nx;

   // Bring the raw key into the clock domain; idle (released) level is 1.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         key_meta <= 1'b1;
         key_sync <= 1'b1;
      end else begin
         key_meta <= key_n;
         key_sync <= key_meta;
      end
   end

   assign pressed_s = ~key_sync;

   // State, counter and all outputs are registered from the next-state logic.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state         <= RELEASED;
         cnt           <= '0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         key_down      <= 1'b0;
      end else begin
         state         <= state_nx;
         cnt           <= cnt_nx;
         press_pulse   <= press_nx;
         release_pulse <= release_nx;
         key_down      <= key_down_nx;
      end
   end

   // Next state: any disagreeing sample during a wait aborts back to the
   // stable state, so every bounce restarts the count from zero.
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      press_nx   = 1'b0;
      release_nx = 1'b0;
      case (state)
         RELEASED: begin
            cnt_nx = '0;
            if (pressed_s) state_nx = PRESS_WAIT;
         end
         PRESS_WAIT: begin
            if (!pressed_s) begin
               state_nx = RELEASED;
               cnt_nx   = '0;
            end else if (cnt == CNT_MAX) begin
               state_nx = PRESSED;
               cnt_nx   = '0;
               press_nx = 1'b1;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         PRESSED: begin
            cnt_nx = '0;
            if (!pressed_s) state_nx = RELEASE_WAIT;
         end
         RELEASE_WAIT: begin
            if (pressed_s) begin
               state_nx = PRESSED;
               cnt_nx   = '0;
            end else if (cnt == CNT_MAX) begin
               state_nx   = RELEASED;
               cnt_nx     = '0;
               release_nx = 1'b1;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         default: begin
            state_nx = RELEASED;
            cnt_nx   = '0;
         end
      endcase
      key_down_nx = (state_nx == PRESSED) || (state_nx == RELEASE_WAIT);
   end

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Directed bench for key_debounce_pulse with DEBOUNCE_CYCLES = 4.
// Expected pulses (kind + cycle) are queued when stimulus is applied; a
// monitor pops and compares whenever a pulse appears.
module tb_key_debounce_pulse;

   logic clock = 1'b0;
   logic resetn;
   logic key_n;
   logic press_pulse, release_pulse, key_down;

   typedef struct {
      bit rel;
      int cyc;
   } ev_t;

   ev_t q[$];
   int  cyc = 0;
   int  n_pass = 0;
   int  n_total = 0;

   key_debounce_pulse #(.DEBOUNCE_CYCLES(4)) dut (
      .clock         (clock),
      .resetn        (resetn),
      .key_n         (key_n),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .key_down      (key_down)
   );

   always #10 clock = ~clock;

   // Edge counter: at a falling edge, cyc is the index of the last rising edge.
   always @(posedge clock) cyc++;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic push(input bit rel, input int at);
      ev_t e;
      e.rel = rel;
      e.cyc = at;
      q.push_back(e);
   endtask

   // Monitor: every observed pulse must match the head of the scoreboard.
   always @(negedge clock) begin
      ev_t e;
      if (press_pulse || release_pulse) begin
         if (q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_pulse: press=%0b release=%0b at cycle %0d, none expected",
                     press_pulse, release_pulse, cyc);
         end else begin
            e = q.pop_front();
            chk("pulse_kind", {press_pulse, release_pulse}, e.rel ? 2 'b01 : 2'b10);
            chk("pulse_cycle", cyc, e.cyc);
         end
      end
   end

   initial begin
      resetn = 1'b0;
      key_n  = 1'b1;
      tick(3);
      chk("rst_press", press_pulse, 0);
      chk("rst_release", release_pulse, 0);
      chk("rst_key_down", key_down, 0);
      resetn = 1'b1;
      tick(3);

      // Clean press, held 100 cycles, then release.
      key_n = 1'b0;
      push(0, cyc + 7);
      tick(6);
      chk("clean_kd_before", key_down, 0);
      tick(1);
      chk("clean_kd_rise", key_down, 1);
      tick(93);
      chk("hold_kd", key_down, 1);
      key_n = 1'b1;
      push(1, cyc + 7);
      tick(6);
      chk("rel_kd_before", key_down, 1);
      tick(1);
      chk("rel_kd_fall", key_down, 0);
      tick(5);

      // Bounce: low 3, high 1, then low and held.
      key_n = 1'b0;
      tick(3);
      key_n = 1'b1;
      tick(1);
      key_n = 1'b0;
      push(0, cyc + 7);
      tick(10);
      chk("bounce_kd", key_down, 1);
      key_n = 1'b1;
      push(1, cyc + 7);
      tick(10);
      chk("bounce_rel_kd", key_down, 0);

      // Reset for one cycle while waiting on a press, key kept low.
      key_n = 1'b0;
      tick(3);
      resetn = 1'b0;
      tick(1);
      chk("midrst_press", press_pulse, 0);
      chk("midrst_release", release_pulse, 0);
      chk("midrst_key_down", key_down, 0);
      resetn = 1'b1;
      push(0, cyc + 7);
      tick(6);
      chk("postrst_kd_before", key_down, 0);
      tick(1);
      chk("postrst_kd_rise", key_down, 1);
      key_n = 1'b1;
      push(1, cyc + 7);
      tick(10);
      chk("postrst_rel_kd", key_down, 0);

      // Short glitch: two cycles low must never register.
      key_n = 1'b0;
      tick(2);
      key_n = 1'b1;
      for (int i = 0; i < 15; i++) begin
         tick(1);
         chk("glitch_kd", key_down, 0);
      end

      tick(2);
      chk("sb_empty", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
